// File: rtl/xor_decrypt_module.sv
// Receive-side XOR stream decryptor: pairs ciphertext bytes with chaotic key words in order
// and emits plaintext, with a small ciphertext FIFO and a length-bounded frame FSM.
module xor_decrypt_module #(
    parameter int DATA_WIDTH = 12,
    parameter int OUT_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    input  logic [OUT_WIDTH-1:0]  ciphertext,
    input  logic                  ciphertext_valid,
    output logic                  ciphertext_ready,
    input  logic [DATA_WIDTH-1:0] key_out,
    input  logic                  key_valid,
    output logic                  key_ready,
    output logic [OUT_WIDTH-1:0]  plaintext,
    output logic                  plaintext_valid,
    input  logic                  plaintext_ready,
    output logic                  busy,
    output logic                  done
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] in_cnt_q, in_cnt_d;
    logic [LEN_WIDTH-1:0] key_cnt_q, key_cnt_d;
    logic [LEN_WIDTH-1:0] out_cnt_q, out_cnt_d;
    logic [OUT_WIDTH-1:0] fifo_q [FIFO_DEPTH];
    logic [PTR_W:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]       rd_ptr_q, rd_ptr_d;
    logic [OUT_WIDTH-1:0] slot_q, slot_d;
    logic                 slot_vld_q, slot_vld_d;
    logic [OUT_WIDTH-1:0] pt_q, pt_d;
    logic                 pt_vld_q, pt_vld_d;

    logic                 run;
    logic                 start_ok;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [OUT_WIDTH-1:0] fifo_head;
    logic                 ct_push;
    logic                 key_load;
    logic                 fire;
    logic                 out_hs;
    logic                 last_hs;
    logic [LEN_WIDTH-1:0] out_cnt_inc;
    logic                 unused_key_hi;

    assign run        = (state_q == S_RUN);
    assign start_ok   = (state_q == S_IDLE) && start;
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign fifo_head  = fifo_q[rd_ptr_q[PTR_W-1:0]];

    assign ciphertext_ready = run && !fifo_full && (in_cnt_q < len_q);
    assign fire             = run && !fifo_empty && slot_vld_q && (!pt_vld_q || plaintext_ready);
    assign key_ready        = run && (!slot_vld_q || fire) && (key_cnt_q < len_q);

    assign ct_push     = ciphertext_valid && ciphertext_ready;
    assign key_load    = key_valid && key_ready;
    assign out_hs      = pt_vld_q && plaintext_ready;
    assign out_cnt_inc = out_cnt_q + 1'b1;
    assign last_hs     = run && out_hs && (out_cnt_inc == len_q);

    assign plaintext       = pt_q;
    assign plaintext_valid = pt_vld_q;
    assign busy            = run;
    assign done            = (state_q == S_DONE);

    // Only the low byte of each key word participates in decryption.
    assign unused_key_hi = ^key_out[DATA_WIDTH-1:OUT_WIDTH];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (frame_len != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (last_hs) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        len_d      = len_q;
        in_cnt_d   = in_cnt_q;
        key_cnt_d  = key_cnt_q;
        out_cnt_d  = out_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        slot_d     = slot_q;
        slot_vld_d = slot_vld_q;
        pt_d       = pt_q;
        pt_vld_d   = pt_vld_q;

        if (start_ok) begin
            len_d     = frame_len;
            in_cnt_d  = '0;
            key_cnt_d = '0;
            out_cnt_d = '0;
        end

        if (ct_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            in_cnt_d = in_cnt_q + 1'b1;
        end

        if (fire) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            slot_vld_d = 1'b0;
            pt_d       = fifo_head ^ slot_q;
            pt_vld_d   = 1'b1;
        end else if (out_hs) begin
            pt_vld_d = 1'b0;
        end

        // A refill in the same cycle as a consume wins, leaving the slot full.
        if (key_load) begin
            slot_d     = key_out[OUT_WIDTH-1:0];
            slot_vld_d = 1'b1;
            key_cnt_d  = key_cnt_q + 1'b1;
        end

        if (out_hs) begin
            out_cnt_d = out_cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (ct_push) begin
            fifo_q[wr_ptr_q[PTR_W-1:0]] <= ciphertext;
        end
        slot_q <= slot_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            in_cnt_q   <= '0;
            key_cnt_q  <= '0;
            out_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            slot_vld_q <= 1'b0;
            pt_q       <= '0;
            pt_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            in_cnt_q   <= in_cnt_d;
            key_cnt_q  <= key_cnt_d;
            out_cnt_q  <= out_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            slot_vld_q <= slot_vld_d;
            pt_q       <= pt_d;
            pt_vld_q   <= pt_vld_d;
        end
    end

endmodule

// File: tb/tb_xor_decrypt_module.sv
// Directed bench for xor_decrypt_module: a frame-level model of the decryptor is checked every
// cycle, and each scenario also pins a few hand-computed values.
module tb_xor_decrypt_module;
    localparam int DW = 12;
    localparam int OW = 8;
    localparam int LW = 16;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] frame_len = '0;
    logic [OW-1:0] ciphertext = '0;
    logic          ciphertext_valid = 1'b0;
    logic          ciphertext_ready;
    logic [DW-1:0] key_out = '0;
    logic          key_valid = 1'b0;
    logic          key_ready;
    logic [OW-1:0] plaintext;
    logic          plaintext_valid;
    logic          plaintext_ready = 1'b0;
    logic          busy;
    logic          done;

    xor_decrypt_module #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .FIFO_DEPTH(4), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
        .ciphertext(ciphertext), .ciphertext_valid(ciphertext_valid),
        .ciphertext_ready(ciphertext_ready),
        .key_out(key_out), .key_valid(key_valid), .key_ready(key_ready),
        .plaintext(plaintext), .plaintext_valid(plaintext_valid),
        .plaintext_ready(plaintext_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame-level model: what has been accepted, and what the n-th output must be.
    int            m_state = M_IDLE;
    bit            m_armed = 1'b0;
    bit            m_reset_seen = 1'b0;
    bit            m_stall = 1'b0;
    int            m_len = 0;
    int            m_nct = 0;
    int            m_nkey = 0;
    int            m_out = 0;
    int            m_cyc = 0;
    logic [OW-1:0] m_ct  [0:63];
    logic [DW-1:0] m_key [0:63];
    logic [OW-1:0] m_got [0:63];
    int            m_hs_cyc [0:63];

    always @(negedge clk) begin
        m_cyc++;
        if (m_armed) begin
            chk("busy", busy, m_state == M_RUN);
            chk("done", done, m_state == M_DONE);
            if (m_state != M_RUN) begin
                chk("ct_ready_idle", ciphertext_ready, 0);
                chk("key_ready_idle", key_ready, 0);
                chk("pt_valid_idle", plaintext_valid, 0);
            end
            if (m_reset_seen) chk("pt_after_reset", plaintext, 0);
            if (m_state == M_RUN) begin
                if (m_nct == m_len) chk("ct_ready_at_len", ciphertext_ready, 0);
                if (m_nkey == m_len) chk("key_ready_at_len", key_ready, 0);
                if (m_stall) chk("pt_hold_valid", plaintext_valid, 1);
                if (plaintext_valid) begin
                    if (m_out < m_nct && m_out < m_nkey)
                        chk("pt_value", plaintext, m_ct[m_out] ^ m_key[m_out][OW-1:0]);
                    else
                        chk("pt_without_inputs", plaintext_valid, 0);
                end
            end
        end
        // Advance the model by the events the coming rising edge will take.
        if (rst) begin
            m_state = M_IDLE; m_nct = 0; m_nkey = 0; m_out = 0; m_len = 0;
            m_armed = 1'b1; m_reset_seen = 1'b1; m_stall = 1'b0;
        end else begin
            m_reset_seen = 1'b0;
            m_stall = (m_state == M_RUN) && plaintext_valid && !plaintext_ready;
            case (m_state)
                M_IDLE: if (start) begin
                    m_len = int'(frame_len); m_nct = 0; m_nkey = 0; m_out = 0;
                    m_state = (frame_len == 0) ? M_DONE : M_RUN;
                end
                M_RUN: begin
                    if (plaintext_valid && plaintext_ready) begin
                        m_got[m_out] = plaintext;
                        m_hs_cyc[m_out] = m_cyc;
                        m_out++;
                        if (m_out == m_len) m_state = M_DONE;
                    end
                    if (ciphertext_valid && ciphertext_ready) begin
                        m_ct[m_nct] = ciphertext; m_nct++;
                    end
                    if (key_valid && key_ready) begin
                        m_key[m_nkey] = key_out; m_nkey++;
                    end
                end
                default: m_state = M_IDLE;
            endcase
        end
    end

    // Stimulus sources.
    logic [OW-1:0] ct_src  [0:15];
    logic [DW-1:0] key_src [0:15];
    int ct_n = 0, key_n = 0, ct_idx = 0, key_idx = 0;
    bit ct_en = 1'b0, key_en = 1'b0;

    task automatic drive();
        ciphertext_valid = ct_en && (ct_idx < ct_n);
        ciphertext       = (ct_idx < ct_n) ? ct_src[ct_idx] : '0;
        key_valid        = key_en && (key_idx < key_n);
        key_out          = (key_idx < key_n) ? key_src[key_idx] : '0;
    endtask

    task automatic tick();
        bit ct_hs, k_hs;
        @(negedge clk);
        ct_hs = ciphertext_valid && ciphertext_ready;
        k_hs  = key_valid && key_ready;
        @(posedge clk);
        #1;
        if (ct_hs) ct_idx++;
        if (k_hs) key_idx++;
        drive();
        #1;
    endtask

    task automatic load_stream(input int n);
        for (int i = 0; i < n; i++) begin
            ct_src[i]  = 8'(8'h07 + 8'(i) * 8'h1D);
            key_src[i] = 12'(12'h05A + 12'(i) * 12'h123);
        end
        ct_n = n; key_n = n; ct_idx = 0; key_idx = 0;
    endtask

    task automatic begin_frame(input int len);
        start = 1'b1; frame_len = LW'(len);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!done && n < limit) begin tick(); n++; end
        chk("done_reached", done, 1);
        tick();
    endtask

    task automatic wait_got(input int cnt, input int limit);
        int n = 0;
        while (m_out < cnt && n < limit) begin tick(); n++; end
        chk("got_reached", m_out >= cnt, 1);
    endtask

    initial begin
        logic [OW-1:0] held;
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [OW-1:0] held;
        tick(); tick();
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_pt", plaintext, 0);

        // Single byte, with a surplus ciphertext byte that must be refused.
        ct_src[0] = 8'h3C; ct_src[1] = 8'h55; key_src[0] = 12'hA5C;
        ct_n = 2; key_n = 1; ct_idx = 0; key_idx = 0;
        begin_frame(1);
        ct_en = 1'b1; key_en = 1'b1; plaintext_ready = 1'b1; drive();
        chk("single_busy", busy, 1);
        chk("single_ct_ready", ciphertext_ready, 1);
        chk("single_key_ready", key_ready, 1);
        tick();
        chk("single_pv_early", plaintext_valid, 0);
        chk("single_ct_refused", ciphertext_ready, 0);
        tick();
        chk("single_pv", plaintext_valid, 1);
        chk("single_pt", plaintext, 8'h60);
        tick();
        chk("single_done", done, 1);
        chk("single_busy_low", busy, 0);
        tick();
        chk("single_done_pulse", done, 0);
        chk("single_ct_count", ct_idx, 1);
        ct_en = 1'b0; key_en = 1'b0; drive();

        // Streaming, one byte per cycle.
        load_stream(8);
        ct_en = 1'b1; key_en = 1'b1; drive();
        begin_frame(8);
        wait_done(40);
        chk("stream_count", m_out, 8);
        chk("stream_first", m_got[0], 8'h5D);
        chk("stream_last", m_got[7], 8'h9D);
        chk("stream_back_to_back", m_hs_cyc[7] - m_hs_cyc[0], 7);

        // Key starvation fills the FIFO.
        ct_src[0] = 8'h11; ct_src[1] = 8'h22; ct_src[2] = 8'h33;
        ct_src[3] = 8'h44; ct_src[4] = 8'h55; ct_src[5] = 8'h66;
        key_src[0] = 12'h1F0; key_src[1] = 12'h2E1; key_src[2] = 12'h3D2;
        key_src[3] = 12'h4C3; key_src[4] = 12'h5B4; key_src[5] = 12'h6A5;
        ct_n = 6; key_n = 6; ct_idx = 0; key_idx = 0;
        ct_en = 1'b1; key_en = 1'b0; drive();
        begin_frame(6);
        repeat (8) tick();
        chk("starve_accepted", ct_idx, 4);
        chk("starve_ct_ready", ciphertext_ready, 0);
        chk("starve_pv", plaintext_valid, 0);
        key_en = 1'b1; drive();
        wait_done(60);
        chk("starve_count", m_out, 6);
        chk("starve_b0", m_got[0], 8'hE1);
        chk("starve_b3", m_got[3], 8'h87);

        // Backpressure for 5 cycles mid-frame.
        load_stream(8);
        ct_en = 1'b1; key_en = 1'b1; drive();
        begin_frame(8);
        wait_got(3, 40);
        plaintext_ready = 1'b0;
        held = plaintext;
        chk("bp_held_value", held, 8'h9D);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_pv", plaintext_valid, 1);
            chk("bp_pt", plaintext, held);
        end
        plaintext_ready = 1'b1;
        wait_done(40);
        chk("bp_count", m_out, 8);
        chk("bp_b3", m_got[3], 8'h9D);
        chk("bp_b4", m_got[4], 8'(8'h07 + 8'd4 * 8'h1D) ^ 8'hE6);

        // Zero-length frame.
        ct_en = 1'b0; key_en = 1'b0; drive();
        begin_frame(0);
        chk("zero_done", done, 1);
        chk("zero_ct_ready", ciphertext_ready, 0);
        chk("zero_key_ready", key_ready, 0);
        tick();
        chk("zero_done_pulse", done, 0);

        // Reset in the middle of a 6-byte frame, then a clean 2-byte frame.
        load_stream(6);
        ct_en = 1'b1; key_en = 1'b1; drive();
        begin_frame(6);
        wait_got(3, 40);
        rst = 1'b1;
        tick();
        chk("rst_pt", plaintext, 0);
        chk("rst_pv", plaintext_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ct_ready", ciphertext_ready, 0);
        chk("rst_key_ready", key_ready, 0);
        rst = 1'b0;
        ct_src[0] = 8'hA1; ct_src[1] = 8'hB2; key_src[0] = 12'h3C4; key_src[1] = 12'h0F0;
        ct_n = 2; key_n = 2; ct_idx = 0; key_idx = 0; drive();
        begin_frame(2);
        wait_done(40);
        chk("post_rst_count", m_out, 2);
        chk("post_rst_b0", m_got[0], 8'h65);
        chk("post_rst_b1", m_got[1], 8'h42);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/xor_decrypt_module.md
# xor_decrypt_module

Receive-side counterpart of the XOR stream encryptor. Accepts a frame of ciphertext bytes over a valid/ready interface and the matching chaotic key words from the key generator. It pairs them strictly in order (byte i with key i) and outputs plaintext = ciphertext ^ key_out[OUT_WIDTH-1:0] over a valid/ready interface. A small ciphertext FIFO absorbs key-generator latency. A frame FSM bounds each transfer to a programmed length and signals completion.

## Interface
- DATA_WIDTH, 12, key word width from the key generator
- OUT_WIDTH, 8, ciphertext/plaintext byte width; only key_out[OUT_WIDTH-1:0] is used
- FIFO_DEPTH, 4, ciphertext FIFO entries (power of two, ≥2)
- LEN_WIDTH, 16, width of frame length and counters

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame, honoured only in IDLE
- frame_len  in  LEN_WIDTH  bytes in frame, sampled on accepted start
- ciphertext  in  OUT_WIDTH  incoming encrypted byte
- ciphertext_valid  in  1  ciphertext qualifier
- ciphertext_ready  out  1  ciphertext accepted when valid && ready
- key_out  in  DATA_WIDTH  key word from the generator
- key_valid  in  1  key qualifier
- key_ready  out  1  key accepted when key_valid && key_ready
- plaintext  out  OUT_WIDTH  decrypted byte
- plaintext_valid  out  1  plaintext qualifier
- plaintext_ready  in  1  downstream accept
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at frame end

## Operation
- States: IDLE, RUN, DONE.
- IDLE: ciphertext_ready = key_ready = 0. On start, latch frame_len and clear in_cnt, key_cnt, out_cnt.
  - frame_len ≠ 0 → RUN.
  - frame_len = 0 → DONE.
- RUN:
  - ciphertext_ready = FIFO not full && in_cnt < len. Each accept pushes one byte and increments in_cnt.
  - Key holding slot has one entry. key_ready = (slot empty || slot consumed this cycle) && key_cnt < len. Each accept loads the slot and increments key_cnt.
  - Pair fire: FIFO non-empty && slot full && (!plaintext_valid || plaintext_ready).
  - On fire: pop FIFO, empty the slot (unless refilled the same cycle), load plaintext = head ^ slot[OUT_WIDTH-1:0], set plaintext_valid.
  - plaintext_valid and plaintext hold stable until plaintext_ready. Drop plaintext_valid on handshake when there is no fire.
  - out_cnt increments on each plaintext handshake. When out_cnt reaches len (the handshake of the last byte) → DONE.
- DONE: done = 1 for exactly one cycle, then → IDLE. start in DONE is ignored.
- busy = (state == RUN).
- Simultaneous events:
  - FIFO push and pop in the same cycle are both performed.
  - FIFO full with a pop in the same cycle: ciphertext_ready is still 0 (ready is based on registered fullness).
  - Key-slot consume and refill in the same cycle leave the slot full with the new key.
- Counters and FIFO pointers wrap naturally. Counters never exceed len, so no overflow occurs.
- Upper key bits [DATA_WIDTH-1:OUT_WIDTH] are discarded.

## Timing
- Reset, applied any cycle including mid-frame, aborts the frame and discards FIFO and key contents. Next-cycle values:
  - state = IDLE; FIFO empty; key slot empty; counters 0
  - plaintext = 0, plaintext_valid = 0, done = 0, busy = 0, ciphertext_ready = 0, key_ready = 0
- start accepted in cycle T → busy = 1 in T+1; ready outputs can assert in T+1.
- If the key slot is already full, a ciphertext byte accepted in cycle N gives plaintext_valid in N+2.
- If ciphertext is waiting, a key accepted in cycle K gives plaintext_valid in K+2.
- Sustained throughput is one byte per cycle with keys and plaintext_ready continuously available.
- done asserts the cycle after the final plaintext handshake. busy falls in that same cycle.

## Test plan
- Single byte: frame_len = 1, key_out = 12'hA5C, ciphertext = 8'h3C → plaintext = 8'h60 two cycles after the later of the two inputs; done pulses once; excess ciphertext is refused (ready = 0).
- Streaming: frame_len = 8, keys and ciphertext every cycle, plaintext_ready = 1 → 8 correct bytes on consecutive cycles; done the cycle after the 8th handshake.
- Key starvation: 4 ciphertext bytes sent while key_valid = 0 → FIFO fills and ciphertext_ready drops after 4 accepts; keys then arrive and all 4 bytes emerge in order.
- Backpressure: plaintext_ready held low for 5 cycles mid-frame → plaintext holds its value and valid stays high; no byte is lost or duplicated; order is preserved.
- Zero length and mid-frame reset: frame_len = 0 → done in the cycle after start with no ready asserted. rst asserted after 3 of 6 bytes → all outputs return to reset values the next cycle; a new start with frame_len = 2 decrypts correctly with no stale data.
